// File: rtl/aes_stream_sink.sv
`default_nettype none
// ============================================================================
// Module   : aes_stream_sink
// Brief    : Collects 32-bit stream words into 128-bit AES blocks and hands
//            each block downstream over a valid/ready port.
// Revision : 1.0
// ============================================================================
module aes_stream_sink #(
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  clear_i,
    input  logic                                  start_i,
    input  logic [CNT_WIDTH-1:0]                  nblocks_i,
    input  logic                                  d_valid_i,
    input  logic [DATA_WIDTH-1:0]                 d_data_i,
    input  logic [DATA_WIDTH/8-1:0]               d_strb_i,
    output logic                                  d_ready_o,
    output logic                                  blk_valid_o,
    output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] blk_data_o,
    input  logic                                  blk_ready_i,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic [CNT_WIDTH-1:0]                  blk_cnt_o,
    output logic                                  strb_err_o
);

    localparam int IDX_WIDTH = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam logic [IDX_WIDTH-1:0] C_LAST_IDX = IDX_WIDTH'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_OUTPUT  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                                r_state;
    state_t                                w_state_next;
    logic [IDX_WIDTH-1:0]                  r_word_idx;
    logic [CNT_WIDTH-1:0]                  r_nblocks;
    logic [CNT_WIDTH-1:0]                  r_blk_cnt;
    logic                                  r_strb_err;
    logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] r_blk_data;

    logic                 w_start;
    logic                 w_word_xfer;
    logic                 w_blk_xfer;
    logic                 w_last_word;
    logic [CNT_WIDTH-1:0] w_cnt_inc;

    assign w_start     = (r_state == S_IDLE) && start_i;
    assign w_word_xfer = (r_state == S_COLLECT) && d_valid_i;
    assign w_blk_xfer  = (r_state == S_OUTPUT) && blk_ready_i;
    assign w_last_word = (r_word_idx == C_LAST_IDX);
    assign w_cnt_inc   = r_blk_cnt + CNT_WIDTH'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear_i) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        w_state_next = (nblocks_i == '0) ? S_DONE : S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (w_word_xfer && w_last_word) begin
                        w_state_next = S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (w_blk_xfer) begin
                        w_state_next = (w_cnt_inc == r_nblocks) ? S_DONE : S_COLLECT;
                    end
                end
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Clear drops any word or block handshaking in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_word_idx <= '0;
            r_nblocks  <= '0;
            r_blk_cnt  <= '0;
            r_strb_err <= 1'b0;
            r_blk_data <= '0;
        end else if (clear_i) begin
            r_word_idx <= '0;
            r_nblocks  <= '0;
            r_blk_cnt  <= '0;
            r_strb_err <= 1'b0;
            r_blk_data <= '0;
        end else begin
            if (w_start) begin
                r_nblocks  <= nblocks_i;
                r_blk_cnt  <= '0;
                r_strb_err <= 1'b0;
                r_word_idx <= '0;
            end
            if (w_word_xfer) begin
                r_blk_data[r_word_idx*DATA_WIDTH +: DATA_WIDTH] <= d_data_i;
                r_word_idx <= w_last_word ? '0 : r_word_idx + IDX_WIDTH'(1);
                if (d_strb_i != '1) begin
                    r_strb_err <= 1'b1;
                end
            end
            if (w_blk_xfer) begin
                r_blk_cnt <= w_cnt_inc;
            end
        end
    end

    assign d_ready_o   = (r_state == S_COLLECT);
    assign blk_valid_o = (r_state == S_OUTPUT);
    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = (r_state == S_DONE);
    assign blk_data_o  = r_blk_data;
    assign blk_cnt_o   = r_blk_cnt;
    assign strb_err_o  = r_strb_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_stream_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_stream_sink
// Brief    : Directed self-checking bench for aes_stream_sink.
// Revision : 1.0
// ============================================================================
module tb_aes_stream_sink;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         clear_i;
    logic         start_i;
    logic [15:0]  nblocks_i;
    logic         d_valid_i;
    logic [31:0]  d_data_i;
    logic [3:0]   d_strb_i;
    logic         d_ready_o;
    logic         blk_valid_o;
    logic [127:0] blk_data_o;
    logic         blk_ready_i;
    logic         busy_o;
    logic         done_o;
    logic [15:0]  blk_cnt_o;
    logic         strb_err_o;

    int checks   = 0;
    int failures = 0;
    int words    = 0;
    int blocks   = 0;
    int dones    = 0;

    aes_stream_sink dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .start_i     (start_i),
        .nblocks_i   (nblocks_i),
        .d_valid_i   (d_valid_i),
        .d_data_i    (d_data_i),
        .d_strb_i    (d_strb_i),
        .d_ready_o   (d_ready_o),
        .blk_valid_o (blk_valid_o),
        .blk_data_o  (blk_data_o),
        .blk_ready_i (blk_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .blk_cnt_o   (blk_cnt_o),
        .strb_err_o  (strb_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: count handshakes at the edge, land on the negedge.
    task automatic step();
        @(posedge clk_i);
        if (d_valid_i && d_ready_o) words++;
        if (blk_valid_o && blk_ready_i) blocks++;
        @(negedge clk_i);
        if (done_o) dones++;
    endtask

    task automatic do_start(input logic [15:0] n);
        start_i   = 1'b1;
        nblocks_i = n;
        step();
        start_i   = 1'b0;
        nblocks_i = 16'hFFFF;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [3:0] s);
        d_valid_i = 1'b1;
        d_data_i  = w;
        d_strb_i  = s;
        step();
        d_valid_i = 1'b0;
        d_strb_i  = 4'hF;
    endtask

    initial begin
        logic [127:0] held;
        logic [127:0] exp_blk;
        int           stall;
        int           nblk;
        int           cyc;

        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        start_i     = 1'b0;
        nblocks_i   = '0;
        d_valid_i   = 1'b0;
        d_data_i    = '0;
        d_strb_i    = 4'hF;
        blk_ready_i = 1'b0;

        // Reset state, then async reset in the middle of a block.
        @(negedge clk_i);
        chk("rst_outputs", {d_ready_o, blk_valid_o, busy_o, done_o, strb_err_o}, 0);
        chk("rst_cnt_data", {blk_cnt_o, blk_data_o[111:0]}, 0);
        rst_ni = 1'b1;
        step();
        do_start(16'd1);
        chk("collect_ready", d_ready_o, 1'b1);
        send_word(32'hDEAD0001, 4'hF);
        send_word(32'hDEAD0002, 4'hF);
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_outputs", {d_ready_o, blk_valid_o, busy_o, done_o, strb_err_o}, 0);
        chk("midrst_data", {blk_cnt_o, blk_data_o[111:0]}, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        chk("postrst_idle", {d_ready_o, busy_o}, 0);

        // Single block, back to back, downstream always ready.
        blk_ready_i = 1'b1;
        dones = 0;
        do_start(16'd1);
        send_word(32'h00000001, 4'hF);
        send_word(32'h00000002, 4'hF);
        send_word(32'h00000003, 4'hF);
        send_word(32'h00000004, 4'hF);
        chk("single_valid", {blk_valid_o, d_ready_o}, 2'b10);
        chk("single_data", blk_data_o, 128'h00000004_00000003_00000002_00000001);
        step();
        chk("single_done", {done_o, busy_o}, 2'b11);
        chk("single_cnt", blk_cnt_o, 16'd1);
        step();
        chk("single_idle", {done_o, busy_o}, 2'b00);
        chk("single_dones", dones, 1);
        chk("single_cnt_hold", blk_cnt_o, 16'd1);

        // Two blocks with input gaps and three cycles of downstream stall.
        blk_ready_i = 1'b0;
        dones = 0;
        words = 0;
        stall = 0;
        nblk  = 0;
        held  = '0;
        do_start(16'd2);
        for (cyc = 0; cyc < 80 && dones == 0; cyc++) begin
            if (blk_valid_o) begin
                exp_blk = {32'hA0000003 + 32'(4*nblk), 32'hA0000002 + 32'(4*nblk),
                           32'hA0000001 + 32'(4*nblk), 32'hA0000000 + 32'(4*nblk)};
                chk("bp_no_ready", d_ready_o, 1'b0);
                if (stall == 0) chk("bp_data", blk_data_o, exp_blk);
                else            chk("bp_stable", blk_data_o, held);
                held        = blk_data_o;
                blk_ready_i = (stall >= 3);
                if (stall >= 3) begin
                    stall = 0;
                    nblk++;
                end else begin
                    stall++;
                end
            end else begin
                blk_ready_i = 1'b0;
            end
            d_valid_i = (cyc % 3 != 1);
            d_data_i  = 32'hA0000000 + 32'(words);
            step();
        end
        d_valid_i   = 1'b0;
        blk_ready_i = 1'b0;
        chk("bp_dones", dones, 1);
        chk("bp_words", words, 8);
        chk("bp_cnt", blk_cnt_o, 16'd2);
        step();
        chk("bp_one_done", dones, 1);

        // Strobe error: flagged from the next cycle, data kept intact.
        blk_ready_i = 1'b1;
        do_start(16'd1);
        chk("strb_clear_on_start", strb_err_o, 1'b0);
        send_word(32'h11111111, 4'hF);
        send_word(32'h22222222, 4'hF);
        chk("strb_before", strb_err_o, 1'b0);
        send_word(32'h33333333, 4'b0111);
        chk("strb_set", strb_err_o, 1'b1);
        send_word(32'h44444444, 4'hF);
        chk("strb_data", blk_data_o, 128'h44444444_33333333_22222222_11111111);
        step();
        step();
        chk("strb_sticky", {strb_err_o, busy_o}, 2'b10);

        // Zero blocks: straight to DONE, no words accepted.
        dones = 0;
        words = 0;
        d_valid_i = 1'b1;
        do_start(16'd0);
        chk("zero_done", {done_o, d_ready_o, strb_err_o}, 3'b100);
        step();
        d_valid_i = 1'b0;
        chk("zero_idle", {done_o, busy_o, d_ready_o}, 3'b000);
        chk("zero_words", words, 0);
        chk("zero_dones", dones, 1);

        // Clear while a block handshakes: block dropped, back to IDLE.
        blocks = 0;
        dones  = 0;
        blk_ready_i = 1'b0;
        do_start(16'd2);
        send_word(32'hC0C00000, 4'hF);
        send_word(32'hC0C00001, 4'hF);
        send_word(32'hC0C00002, 4'hF);
        send_word(32'hC0C00003, 4'hF);
        chk("clr_pending", blk_valid_o, 1'b1);
        blk_ready_i = 1'b1;
        clear_i     = 1'b1;
        step();
        clear_i = 1'b0;
        chk("clr_state", {busy_o, blk_valid_o, done_o, d_ready_o}, 4'b0000);
        chk("clr_cnt", blk_cnt_o, 16'd0);
        chk("clr_data", blk_data_o, 128'h0);
        step();
        chk("clr_no_done", dones, 0);
        do_start(16'd1);
        send_word(32'h0000BEEF, 4'hF);
        send_word(32'h0000CAFE, 4'hF);
        send_word(32'h0000F00D, 4'hF);
        send_word(32'h00001234, 4'hF);
        chk("after_clr_data", blk_data_o, 128'h00001234_0000F00D_0000CAFE_0000BEEF);
        step();
        chk("after_clr_done", {done_o, blk_cnt_o}, {1'b1, 16'd1});
        step();
        chk("after_clr_idle", busy_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
